// File: rtl/uart_block_tx.sv
// Transmits a 64-bit block as eight UART frames, MSB byte first, each byte LSB first.
// Optional build macro UART_TX_TWO_STOP_EN extends each frame to two stop bits.
module uart_block_tx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        parity_en,
   input  logic        parity_kind,
   input  logic [64:1] data,
   input  logic        load,
   output logic        txd,
   output logic        busy,
   output logic        ft
);

`ifdef UART_TX_TWO_STOP_EN
   localparam int unsigned STOP_CLKS = 2 * CLKS_PER_BIT;
`else
   localparam int unsigned STOP_CLKS = CLKS_PER_BIT;
`endif
   localparam int unsigned BAUD_W = $clog2(STOP_CLKS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]        r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [2:0]        r_byte;
   logic [64:1]       r_data;
   logic              r_par_en;
   logic              r_par_kind;
   logic              r_txd;
   logic              r_ft;

   logic [7:0]        w_byte;
   logic              w_bit_end;
   logic              w_stop_end;
   logic [2:0]        w_bit_nxt;
   logic              w_parity;

   // The byte on the wire always sits in the top of r_data; it shifts up after each stop.
   assign w_byte     = r_data[64:57];
   assign w_bit_end  = (r_baud == BAUD_LAST);
   assign w_stop_end = (r_baud == STOP_LAST);
   assign w_bit_nxt  = r_bit + 3'd1;
   assign w_parity   = (^w_byte) ^ r_par_kind;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_byte     <= '0;
         r_data     <= '0;
         r_par_en   <= 1'b0;
         r_par_kind <= 1'b0;
         r_txd      <= 1'b1;
         r_ft       <= 1'b0;
      end else begin
         r_ft <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (load) begin
                  r_data     <= data;
                  r_par_en   <= parity_en;
                  r_par_kind <= parity_kind;
                  r_baud     <= '0;
                  r_bit      <= '0;
                  r_byte     <= '0;
                  r_txd      <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_txd   <= w_byte[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_bit <= '0;
                     if (r_par_en) begin
                        r_txd   <= w_parity;
                        r_state <= S_PARITY;
                     end else begin
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_bit <= w_bit_nxt;
                     r_txd <= w_byte[w_bit_nxt];
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_txd   <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (w_stop_end) begin
                  r_baud <= '0;
                  if (r_byte == 3'd7) begin
                     r_byte  <= '0;
                     r_txd   <= 1'b1;
                     r_ft    <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_byte  <= r_byte + 3'd1;
                     r_data  <= {r_data[56:1], 8'h00};
                     r_txd   <= 1'b0;
                     r_state <= S_START;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign txd  = r_txd;
   assign busy = (r_state != S_IDLE);
   assign ft   = r_ft;

endmodule

// File: tb/tb_uart_block_tx.sv
// Bench for uart_block_tx: per-cycle comparison against an offset-based waveform model,
// plus literal byte, parity and timing expectations for directed blocks.
module tb_uart_block_tx;
   localparam int unsigned C = 4;
`ifdef UART_TX_TWO_STOP_EN
   localparam int STOPS = 2;
   localparam int FT_NP = 353;
   localparam int FT_P  = 385;
`else
   localparam int STOPS = 1;
   localparam int FT_NP = 321;
   localparam int FT_P  = 353;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        parity_en = 1'b0;
   logic        parity_kind = 1'b0;
   logic        load = 1'b1;
   logic [64:1] data = '0;
   logic        txd, busy, ft;

   uart_block_tx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .parity_en(parity_en), .parity_kind(parity_kind),
      .data(data), .load(load), .txd(txd), .busy(busy), .ft(ft)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // model state: m_n is the 1-based cycle offset since the accepting edge
   int          cyc = 0;
   bit          m_act = 0;
   int          m_n = 0;
   int          m_L = 0;
   int          m_ks = 0;
   logic [64:1] m_data;
   bit          m_pe, m_pk;
   bit          chk_en = 0;
   int          ft_cnt = 0;
   int          busy_cnt = 0;
   int          ft_at = 0;
   logic        rec [0:511];

   function automatic int flen(input bit pe);
      return 9 + STOPS + int'(pe);
   endfunction

   function automatic logic exp_bit(input logic [64:1] d, input bit pe, input bit pk, input int n);
      int p, b, pos;
      logic [7:0] by;
      p   = (n - 1) / int'(C);
      b   = p / flen(pe);
      pos = p % flen(pe);
      by  = d[64 - 8*b -: 8];
      if (pos == 0) return 1'b0;
      if (pos <= 8) return by[pos-1];
      if (pe && pos == 9) return (^by) ^ pk;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin : model
      bit busy_before;
      cyc++;
      busy_before = m_act && m_n >= 1 && m_n <= m_L;
      if (rst) m_act = 0;
      else if (!busy_before && load) begin
         m_act = 1; m_n = 1; m_ks = cyc;
         m_data = data; m_pe = parity_en; m_pk = parity_kind;
         m_L = 8 * flen(parity_en) * int'(C);
      end else if (m_act) m_n++;
   end

   always @(negedge clk) begin : compare
      logic e_busy, e_ft, e_txd;
      if (chk_en) begin
         e_busy = m_act && m_n >= 1 && m_n <= m_L;
         e_ft   = m_act && m_n == m_L + 1;
         e_txd  = e_busy ? exp_bit(m_data, m_pe, m_pk, m_n) : 1'b1;
         chk($sformatf("txd@%0d", cyc), 64'(txd), 64'(e_txd));
         chk($sformatf("busy@%0d", cyc), 64'(busy), 64'(e_busy));
         chk($sformatf("ft@%0d", cyc), 64'(ft), 64'(e_ft));
         if (e_busy) rec[m_n] = txd;
         if (ft === 1'b1) ft_cnt++;
         if (busy === 1'b1) busy_cnt++;
      end
   end

   task automatic send(input logic [64:1] d, input bit pe, input bit pk);
      @(negedge clk);
      data = d; parity_en = pe; parity_kind = pk; load = 1'b1; busy_cnt = 0;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_ft(input string tag);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (ft === 1'b1) begin
            ft_at = cyc;
            return;
         end
      end
      tests++; fails++;
      $display("FAIL %s: got no ft expected ft within 1000 cycles", tag);
   endtask

   task automatic wait_n(input int target, input string tag);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (m_act && m_n >= target) return;
      end
      tests++; fails++;
      $display("FAIL %s: got offset %0d expected %0d", tag, m_n, target);
   endtask

   task automatic check_bytes(input string tag, input logic [64:1] exp_d, input bit pe);
      logic [7:0] got, want;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 8; i++)
            got[i] = rec[(b * flen(pe) + 1 + i) * int'(C) + 2];
         want = exp_d[64 - 8*b -: 8];
         chk($sformatf("%s_byte%0d", tag, b), 64'(got), 64'(want));
      end
   endtask

   task automatic chk_par(input string tag, input int b, input logic want);
      chk(tag, 64'(rec[(b * flen(1) + 9) * int'(C) + 2]), 64'(want));
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      int ft0, ft1;
      @(posedge clk);
      chk_en = 1;
      // reset with load held high, then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; load = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle_txd", 64'(txd), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ft_count", 64'(ft_cnt), 64'd0);

      // basic block, parity off
      send(64'h0123456789ABCDEF, 1'b0, 1'b0);
      wait_ft("basic");
      chk("basic_ft_cycle", 64'(ft_at + 1 - m_ks), 64'(FT_NP));
      chk("basic_busy_cycles", 64'(busy_cnt), 64'(FT_NP - 1));
      check_bytes("basic", 64'h0123456789ABCDEF, 1'b0);

      // even parity
      send(64'hEF00_0000_0000_0001, 1'b1, 1'b0);
      wait_ft("even");
      chk("even_ft_cycle", 64'(ft_at + 1 - m_ks), 64'(FT_P));
      chk_par("even_par0", 0, 1'b1);
      chk_par("even_par1", 1, 1'b0);
      chk_par("even_par7", 7, 1'b1);

      // odd parity
      send(64'hEF00_0000_0000_0001, 1'b1, 1'b1);
      wait_ft("odd");
      chk("odd_ft_cycle", 64'(ft_at + 1 - m_ks), 64'(FT_P));
      chk_par("odd_par0", 0, 1'b0);
      chk_par("odd_par1", 1, 1'b1);
      chk_par("odd_par7", 7, 1'b0);

      // load and input changes while busy are ignored
      @(negedge clk);
      ft0 = ft_cnt;
      send(64'hA5C3_0F1E_7788_9900, 1'b1, 1'b0);
      wait_n(2 * flen(1) * int'(C) + 3 * int'(C), "hold_wait");
      data = 64'hFFFF_0000_FFFF_0000; parity_kind = 1'b1; parity_en = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_ft("hold");
      check_bytes("hold", 64'hA5C3_0F1E_7788_9900, 1'b1);
      chk_par("hold_par0", 0, 1'b0);
      repeat (50) @(negedge clk);
      chk("hold_ft_count", 64'(ft_cnt - ft0), 64'd1);
      chk("hold_idle_busy", 64'(busy), 64'd0);

      // back-to-back: second load in the ft cycle
      ft0 = ft_cnt;
      send(64'h1357_9BDF_0246_8ACE, 1'b0, 1'b0);
      wait_ft("b2b_first");
      ft1 = ft_at;
      data = 64'hC0DE_CAFE_F00D_BEEF; parity_en = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("b2b_start_txd", 64'(txd), 64'd0);
      chk("b2b_start_busy", 64'(busy), 64'd1);
      wait_ft("b2b_second");
      chk("b2b_ft_gap", 64'(ft_at - ft1), 64'(FT_NP));
      check_bytes("b2b", 64'hC0DE_CAFE_F00D_BEEF, 1'b0);
      @(negedge clk);
      chk("b2b_ft_count", 64'(ft_cnt - ft0), 64'd2);

      // reset during byte 4 data bits
      ft0 = ft_cnt;
      send(64'h1122_3344_5566_7788, 1'b1, 1'b1);
      wait_n(4 * flen(1) * int'(C) + 2 * int'(C) + 1, "rst_wait");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_txd", 64'(txd), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      repeat (400) @(negedge clk);
      chk("rst_no_ft", 64'(ft_cnt - ft0), 64'd0);
      send(64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
      wait_ft("after_rst");
      chk("after_rst_ft_cycle", 64'(ft_at + 1 - m_ks), 64'(FT_NP));
      check_bytes("after_rst", 64'hFEDC_BA98_7654_3210, 1'b0);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_block_tx.md
# uart_block_tx

Serial UART transmitter that sends one 64-bit block as eight consecutive 8-bit frames on a single `txd` line, with optional parity. It is the transmit-side counterpart of the eight-byte UART receiver. The first byte on the wire is the receiver's first byte (r1), so a 64-bit cipher block loaded here arrives byte-for-byte in the same order at the far-end receiver. It sits between the cipher datapath output and the board TX pin.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `parity_en`  input  1  1 = append a parity bit to each frame; sampled at load.
- `parity_kind`  input  1  0 = even, 1 = odd; sampled at load.
- `data`  input  [64:1]  block to send; `data[64:57]` is byte 0 (sent first), `data[8:1]` is byte 7.
- `load`  input  1  start request; accepted only when `busy`=0.
- `txd`  output  1  serial line, idle high.
- `busy`  output  1  high from the cycle after an accepted load until the block completes.
- `ft`  output  1  one-cycle pulse marking block completion.

## Operation
- Frame per byte: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Parity bit: even gives XOR of the 8 data bits; odd gives its inverse.
- FSM states and transitions:
  - IDLE → START on an accepted load.
  - START → DATA.
  - DATA → PARITY after bit 7 if parity is enabled, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → START if byte index < 7; otherwise STOP → IDLE with `ft` pulsed.
- Counters:
  - Baud counter 0..CLKS_PER_BIT-1; each state bit is held for exactly CLKS_PER_BIT cycles.
  - 3-bit bit index and 3-bit byte index, both wrapping from 7 to 0 at end of use.
- On accept, `data`, `parity_en` and `parity_kind` are captured into internal registers. Input changes during the block have no effect.
- `load` while `busy`=1 is ignored, not queued.
- Reset values: `txd`=1, `busy`=0, `ft`=0, state IDLE, all counters 0.
- Reset mid-block: the next cycle shows `txd`=1 and `busy`=0, and no `ft` is pulsed. The partial frame is abandoned.

## Timing
- Let load be accepted at rising edge k.
  - `txd` goes low and `busy` goes high in the cycle after edge k.
  - The start bit of byte 0 occupies cycles k+1 … k+CLKS_PER_BIT.
- Frame length is F = 10 + parity_en bits; block length is 8·F·CLKS_PER_BIT cycles.
- The last stop bit ends at cycle k+8·F·CLKS_PER_BIT. In the following cycle, `ft`=1, `busy`=0 and `txd`=1.
- A new load is accepted in that same `ft` cycle. The next start bit then begins one cycle later, so the minimum idle gap between blocks is 1 cycle.
- Frames within a block are back-to-back: the next start bit immediately follows the stop bit.
- `rst` takes priority over `load` in the same cycle.

## Configuration
- `UART_TX_TWO_STOP_EN`
  - Defined: each frame ends with two stop bits. F = 11 + parity_en, and the STOP state lasts 2·CLKS_PER_BIT cycles.
  - Undefined: one stop bit, as specified above.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 3 cycles with `load`=1, then hold `load`=0.
  - Response: `txd`=1, `busy`=0 and `ft`=0 throughout, with no frame emitted.
- Basic block:
  - Stimulus: CLKS_PER_BIT=4, parity off, `data`=64'h0123456789ABCDEF.
  - Response: the decoded byte sequence is 01,23,45,67,89,AB,CD,EF, with byte 0 bits 1,0,0,0,0,0,0,0. `ft` is high exactly at cycle k+321 and `busy` is high for cycles k+1…k+320.
- Parity:
  - Stimulus: CLKS_PER_BIT=4, `data`=64'hEF00_0000_0000_0001.
  - Even parity response: parity bits 1 (0xEF), 0 (0x00), 1 (0x01).
  - Odd parity response: parity bits 0, 1, 0.
  - Both cases: `ft` at k+353.
- Load while busy and input hold:
  - Stimulus: during byte 2, pulse `load` and change `data`/`parity_kind`.
  - Response: the transmitted bytes are unchanged and exactly one `ft` pulse occurs.
- Back-to-back blocks:
  - Stimulus: assert `load` in the `ft` cycle.
  - Response: the second block's start bit begins the next cycle, and exactly 2 `ft` pulses are 321 cycles apart (parity off).
- Reset mid-block:
  - Stimulus: assert `rst` for 1 cycle during byte 4's data bits.
  - Response: `txd`=1 and `busy`=0 on the next cycle, and no `ft`. A subsequent load sends a full correct block.
